// File: rtl/culsans_exit_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | culsans_exit_monitor                                                       |
// | Multi-hart tohost exit monitor: per-hart debounce, completion, watchdog.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module culsans_exit_monitor #(
  parameter int NumHarts      = 4,
  parameter int ExitWidth     = 32,
  parameter int StableCycles  = 4,
  parameter int TimeoutCycles = 0,
  parameter int CntWidth      = 48,
  localparam int C_HART_W     = (NumHarts > 1) ? $clog2(NumHarts) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          clear_i,
  input  logic                          all_mode_i,
  input  logic [NumHarts-1:0]           hart_en_i,
  input  logic [NumHarts*ExitWidth-1:0] exit_i,
  output logic                          done_o,
  output logic                          pass_o,
  output logic                          fail_o,
  output logic                          timeout_o,
  output logic [C_HART_W-1:0]           fail_hart_o,
  output logic [ExitWidth-2:0]          exit_code_o,
  output logic [NumHarts-1:0]           harts_done_o,
  output logic [CntWidth-1:0]           cycles_o
);

  localparam logic [7:0]          c_stable  = 8'(StableCycles);
  localparam bit                  c_wd_en   = (TimeoutCycles != 0);
  localparam logic [CntWidth-1:0] c_wd_last = c_wd_en ? CntWidth'(TimeoutCycles - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_fail;
  logic                  r_timeout;
  logic [C_HART_W-1:0]   r_fail_hart;
  logic [ExitWidth-2:0]  r_exit_code;
  logic [NumHarts-1:0]   r_harts_done;
  logic [CntWidth-1:0]   r_cycles;

  logic                  w_run;
  logic                  w_arm;
  logic [NumHarts-1:0]   w_accept;
  logic [NumHarts-1:0]   w_code_nz;
  logic [NumHarts-1:0]   w_fail_vec;
  logic [C_HART_W-1:0]   w_fail_idx;
  logic [ExitWidth-2:0]  w_fail_code;
  logic                  w_complete;
  logic                  w_wd_expire;

  assign w_run = (r_state == S_RUN);
  assign w_arm = (r_state == S_IDLE) && start_i && !clear_i;

  for (genvar h = 0; h < NumHarts; h++) begin : g_hart
    logic [ExitWidth-1:0] w_word;
    logic [7:0]           w_cnt_next;
    logic [ExitWidth-1:0] r_shadow;
    logic [7:0]           r_cnt;

    assign w_word = exit_i[h*ExitWidth +: ExitWidth];

    always_comb begin
      w_cnt_next = '0;
      if (w_word[0] && (w_word == r_shadow)) begin
        w_cnt_next = (r_cnt == c_stable) ? c_stable : r_cnt + 8'd1;
      end
    end

    assign w_accept[h]  = w_run && hart_en_i[h] && !r_harts_done[h] && (w_cnt_next == c_stable);
    assign w_code_nz[h] = |w_word[ExitWidth-1:1];

    // Shadow tracks the previous-cycle word; the counter only advances on live, unfinished harts.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_shadow <= '0;
        r_cnt    <= '0;
      end else if (clear_i) begin
        r_shadow <= '0;
        r_cnt    <= '0;
      end else if (w_arm) begin
        r_shadow <= w_word;
        r_cnt    <= '0;
      end else if (w_run) begin
        r_shadow <= w_word;
        r_cnt    <= (hart_en_i[h] && !r_harts_done[h]) ? w_cnt_next : '0;
      end
    end
  end

  assign w_fail_vec = w_accept & w_code_nz;

  // Descending scan leaves the lowest failing hart selected.
  always_comb begin
    w_fail_idx  = '0;
    w_fail_code = '0;
    for (int h = NumHarts - 1; h >= 0; h--) begin
      if (w_fail_vec[h]) begin
        w_fail_idx  = C_HART_W'(h);
        w_fail_code = exit_i[h*ExitWidth+1 +: ExitWidth-1];
      end
    end
  end

  always_comb begin
    w_complete = 1'b0;
    if (w_run) begin
      if (all_mode_i) begin
        w_complete = ((((r_harts_done | w_accept) & hart_en_i) == hart_en_i) || (|w_fail_vec));
      end else begin
        w_complete = |w_accept;
      end
    end
  end

  assign w_wd_expire = c_wd_en && w_run && (r_cycles == c_wd_last);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_fail_hart  <= '0;
      r_exit_code  <= '0;
      r_harts_done <= '0;
      r_cycles     <= '0;
    end else if (clear_i) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_fail_hart  <= '0;
      r_exit_code  <= '0;
      r_harts_done <= '0;
      r_cycles     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state      <= S_RUN;
            r_cycles     <= '0;
            r_harts_done <= '0;
          end
        end
        S_RUN: begin
          if (r_cycles != {CntWidth{1'b1}}) begin
            r_cycles <= r_cycles + CntWidth'(1);
          end
          r_harts_done <= r_harts_done | w_accept;
          // Any accepted nonzero code ends the run, so this capture happens at most once.
          if (|w_fail_vec) begin
            r_fail_hart <= w_fail_idx;
            r_exit_code <= w_fail_code;
          end
          if (w_complete) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            if (|w_fail_vec) begin
              r_fail <= 1'b1;
            end else begin
              r_pass <= 1'b1;
            end
          end else if (w_wd_expire) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign done_o       = r_done;
  assign pass_o       = r_pass;
  assign fail_o       = r_fail;
  assign timeout_o    = r_timeout;
  assign fail_hart_o  = r_fail_hart;
  assign exit_code_o  = r_exit_code;
  assign harts_done_o = r_harts_done;
  assign cycles_o     = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_culsans_exit_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_culsans_exit_monitor                                                    |
// | Scoreboard bench for the multi-hart exit monitor (4 harts, 100-cycle WD).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_culsans_exit_monitor;

  localparam int c_harts   = 4;
  localparam int c_width   = 32;
  localparam int c_stable  = 4;
  localparam int c_timeout = 100;
  localparam int c_cnt_w   = 48;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [1:0]  fh;
    logic [30:0] code;
    logic [3:0]  hd;
    logic [47:0] cyc;
  } res_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start;
  logic                        clear;
  logic                        all_mode;
  logic [c_harts-1:0]          hart_en;
  logic [c_harts*c_width-1:0]  exit_w;
  logic                        done;
  logic                        pass;
  logic                        fail;
  logic                        tmo;
  logic [1:0]                  fail_hart;
  logic [c_width-2:0]          exit_code;
  logic [c_harts-1:0]          harts_done;
  logic [c_cnt_w-1:0]          cycles;

  int   n_checks = 0;
  int   n_pass   = 0;
  res_t sb[$];

  culsans_exit_monitor #(
    .NumHarts     (c_harts),
    .ExitWidth    (c_width),
    .StableCycles (c_stable),
    .TimeoutCycles(c_timeout),
    .CntWidth     (c_cnt_w)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .clear_i     (clear),
    .all_mode_i  (all_mode),
    .hart_en_i   (hart_en),
    .exit_i      (exit_w),
    .done_o      (done),
    .pass_o      (pass),
    .fail_o      (fail),
    .timeout_o   (tmo),
    .fail_hart_o (fail_hart),
    .exit_code_o (exit_code),
    .harts_done_o(harts_done),
    .cycles_o    (cycles)
  );

  always #5 clk = ~clk;

  function automatic res_t mk(input logic d, input logic p, input logic f, input logic t,
                              input logic [1:0] fh, input logic [30:0] code,
                              input logic [3:0] hd, input logic [47:0] cyc);
    res_t r;
    r = '{done: d, pass: p, fail: f, tmo: t, fh: fh, code: code, hd: hd, cyc: cyc};
    return r;
  endfunction

  function automatic res_t observed();
    return mk(done, pass, fail, tmo, fail_hart, exit_code, harts_done, cycles);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int h, input logic [31:0] v);
    exit_w[h*c_width +: c_width] = v;
  endtask

  task automatic arm(input logic mode, input logic [3:0] en);
    all_mode = mode;
    hart_en  = en;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic disarm();
    exit_w = '0;
    clear  = 1'b1;
    tick();
    clear  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while (!done && lat < budget) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    res_t obs;
    rst = 1'b1; start = 1'b0; clear = 1'b0; all_mode = 1'b0; hart_en = '0; exit_w = '0;
    tick(); tick();
    obs = observed();
    n_checks++;
    if (obs !== '0) $display("FAIL reset_hold obs=%h exp=0", obs); else n_pass++;
    rst = 1'b0;
    tick(); tick();
    obs = observed();
    n_checks++;
    if (obs !== '0) $display("FAIL reset_idle obs=%h exp=0", obs); else n_pass++;
  endtask

  task automatic test_single_exit();
    int lat;
    res_t e, obs;
    sb.push_back(mk(1, 1, 0, 0, 2'd0, 31'd0, 4'b0100, 48'd5));
    arm(1'b0, 4'b1111);
    set_word(2, 32'h1);
    wait_done(20, lat);
    n_checks++;
    if (lat !== c_stable + 1) $display("FAIL single_latency got=%0d exp=%0d", lat, c_stable + 1);
    else n_pass++;
    e = sb.pop_front();
    obs = observed();
    n_checks++;
    if (obs !== e) $display("FAIL single_result obs=%h exp=%h", obs, e); else n_pass++;
    tick(); tick(); tick();
    obs = observed();
    n_checks++;
    if (obs !== e) $display("FAIL single_hold obs=%h exp=%h", obs, e); else n_pass++;
    disarm();
  endtask

  task automatic test_all_mode();
    int lat;
    res_t e, obs;
    sb.push_back(mk(1, 1, 0, 0, 2'd0, 31'd0, 4'b1011, 48'd8));
    arm(1'b1, 4'b1011);
    set_word(0, 32'h1);
    tick();
    set_word(1, 32'h1);
    tick(); tick();
    set_word(3, 32'h1);
    set_word(2, 32'h3);
    tick(); tick(); tick();
    obs = observed();
    n_checks++;
    if (obs !== mk(0, 0, 0, 0, 2'd0, 31'd0, 4'b0011, 48'd6))
      $display("FAIL all_partial obs=%h exp=%h", obs, mk(0, 0, 0, 0, 2'd0, 31'd0, 4'b0011, 48'd6));
    else n_pass++;
    wait_done(20, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL all_latency got=%0d exp=2", lat); else n_pass++;
    e = sb.pop_front();
    obs = observed();
    n_checks++;
    if (obs !== e) $display("FAIL all_result obs=%h exp=%h", obs, e); else n_pass++;
    disarm();
  endtask

  task automatic test_simultaneous_fail();
    int lat;
    res_t e, obs;
    sb.push_back(mk(1, 0, 1, 0, 2'd1, 31'd3, 4'b1010, 48'd5));
    arm(1'b0, 4'b1111);
    set_word(1, 32'h7);
    set_word(3, 32'h15);
    wait_done(20, lat);
    n_checks++;
    if (lat !== 5) $display("FAIL simfail_latency got=%0d exp=5", lat); else n_pass++;
    e = sb.pop_front();
    obs = observed();
    n_checks++;
    if (obs !== e) $display("FAIL simfail_result obs=%h exp=%h", obs, e); else n_pass++;
    disarm();
  endtask

  task automatic test_debounce_restart();
    int lat;
    res_t e, obs;
    sb.push_back(mk(1, 0, 1, 0, 2'd0, 31'd2, 4'b0001, 48'd8));
    arm(1'b0, 4'b1111);
    set_word(0, 32'h1);
    tick(); tick();
    set_word(0, 32'h0);
    tick();
    set_word(0, 32'h5);
    wait_done(20, lat);
    n_checks++;
    if (lat !== 5) $display("FAIL debounce_latency got=%0d exp=5", lat); else n_pass++;
    e = sb.pop_front();
    obs = observed();
    n_checks++;
    if (obs !== e) $display("FAIL debounce_result obs=%h exp=%h", obs, e); else n_pass++;
    disarm();
  endtask

  task automatic test_empty_all();
    int lat;
    res_t e, obs;
    sb.push_back(mk(1, 1, 0, 0, 2'd0, 31'd0, 4'b0000, 48'd1));
    arm(1'b1, 4'b0000);
    wait_done(10, lat);
    n_checks++;
    if (lat !== 1) $display("FAIL empty_latency got=%0d exp=1", lat); else n_pass++;
    e = sb.pop_front();
    obs = observed();
    n_checks++;
    if (obs !== e) $display("FAIL empty_result obs=%h exp=%h", obs, e); else n_pass++;
    disarm();
  endtask

  task automatic test_timeout();
    int lat;
    res_t e, obs;
    sb.push_back(mk(1, 0, 0, 1, 2'd0, 31'd0, 4'b0000, 48'd100));
    arm(1'b0, 4'b1111);
    wait_done(150, lat);
    n_checks++;
    if (lat !== c_timeout) $display("FAIL timeout_latency got=%0d exp=%0d", lat, c_timeout);
    else n_pass++;
    e = sb.pop_front();
    obs = observed();
    n_checks++;
    if (obs !== e) $display("FAIL timeout_result obs=%h exp=%h", obs, e); else n_pass++;
    tick(); tick(); tick();
    obs = observed();
    n_checks++;
    if (obs !== e) $display("FAIL timeout_frozen obs=%h exp=%h", obs, e); else n_pass++;
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    obs = observed();
    n_checks++;
    if (obs !== '0) $display("FAIL clear_outputs obs=%h exp=0", obs); else n_pass++;
    tick(); tick(); tick();
    obs = observed();
    n_checks++;
    if (obs !== '0) $display("FAIL clear_stays_idle obs=%h exp=0", obs); else n_pass++;
  endtask

  task automatic test_timeout_race();
    int lat;
    res_t e, obs;
    sb.push_back(mk(1, 1, 0, 0, 2'd0, 31'd0, 4'b0001, 48'd100));
    arm(1'b0, 4'b1111);
    for (int i = 0; i < 95; i++) tick();
    set_word(0, 32'h1);
    wait_done(20, lat);
    n_checks++;
    if (lat !== 5) $display("FAIL race_latency got=%0d exp=5", lat); else n_pass++;
    e = sb.pop_front();
    obs = observed();
    n_checks++;
    if (obs !== e) $display("FAIL race_result obs=%h exp=%h", obs, e); else n_pass++;
    disarm();
  endtask

  task automatic test_reset_midrun();
    int lat;
    res_t e, obs;
    arm(1'b1, 4'b1111);
    set_word(0, 32'h1);
    tick(); tick(); tick();
    set_word(1, 32'h1);
    tick(); tick(); tick();
    obs = observed();
    n_checks++;
    if (obs !== mk(0, 0, 0, 0, 2'd0, 31'd0, 4'b0001, 48'd6))
      $display("FAIL midrun_pre obs=%h exp=%h", obs, mk(0, 0, 0, 0, 2'd0, 31'd0, 4'b0001, 48'd6));
    else n_pass++;
    rst = 1'b1;
    #1;
    obs = observed();
    n_checks++;
    if (obs !== '0) $display("FAIL midrun_reset obs=%h exp=0", obs); else n_pass++;
    tick();
    rst = 1'b0;
    set_word(0, 32'h0);
    sb.push_back(mk(1, 1, 0, 0, 2'd0, 31'd0, 4'b0010, 48'd4));
    arm(1'b0, 4'b1111);
    wait_done(20, lat);
    n_checks++;
    if (lat !== c_stable) $display("FAIL rearm_latency got=%0d exp=%0d", lat, c_stable);
    else n_pass++;
    e = sb.pop_front();
    obs = observed();
    n_checks++;
    if (obs !== e) $display("FAIL rearm_result obs=%h exp=%h", obs, e); else n_pass++;
    disarm();
  endtask

  initial begin
    test_reset();
    test_single_exit();
    test_all_mode();
    test_simultaneous_fail();
    test_debounce_restart();
    test_empty_all();
    test_timeout();
    test_timeout_race();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
